// File: rtl/receiver_pkg.sv
// Shared sample-memory layout and transmitter state encoding, common to the
// receiver write side and the transmitter read side.
package receiver_pkg;

  localparam int unsigned RX_ADDR_W = 16;
  localparam int unsigned RX_DATA_W = 16;

  // Interleaved I/Q layout: each pair occupies two consecutive words.
  localparam int unsigned IQ_I_OFS  = 0;
  localparam int unsigned IQ_Q_OFS  = 1;
  localparam int unsigned IQ_STRIDE = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_I   = 3'd1,
    ST_FETCH_Q   = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_WAIT_TICK = 3'd4,
    ST_DRAIN     = 3'd5
  } tx_state_e;

endpackage

// File: rtl/transmitter_output_sample_tick_gen.sv
// Output-rate divider: counts DIV cycles while enabled and flags the last one.
// A synchronous clear holds the count at zero.
module sample_tick_gen #(
  parameter int unsigned DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en) begin
      cnt_d = tick ? 16'd0 : (cnt_q + 16'd1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitter_output.sv
// Reads interleaved I/Q words from sample memory and presents them at a fixed
// rate of one pair per DIV clocks. Define TX_OUTPUT_LOOP_EN to repeat bursts until stop.
module transmitter_output
  import receiver_pkg::*;
#(
  parameter int unsigned ADDR_W = RX_ADDR_W,
  parameter int unsigned DATA_W = RX_DATA_W,
  parameter int unsigned DIV    = 25
) (
  input  logic              dsp_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_samples,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] inphase_output,
  output logic [DATA_W-1:0] quad_output,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       rem_q, rem_d;
  logic [DATA_W-1:0] pend_i_q, pend_i_d, pend_q_q, pend_q_d;
  logic [DATA_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tick;
`ifdef TX_OUTPUT_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       count_q, count_d;
`endif

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (dsp_clk),
    .rst  (rst),
    .en   (busy_q),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    pend_i_d  = pend_i_q;
    pend_q_d  = pend_q_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
`ifdef TX_OUTPUT_LOOP_EN
    base_d    = base_q;
    count_d   = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          ptr_d = base_addr;
          rem_d = num_samples;
`ifdef TX_OUTPUT_LOOP_EN
          base_d  = base_addr;
          count_d = num_samples;
`endif
          if (num_samples == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            state_d   = ST_FETCH_I;
            rd_en_d   = 1'b1;
            rd_addr_d = base_addr + ADDR_W'(IQ_I_OFS);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH_I: begin
        state_d   = ST_FETCH_Q;
        rd_en_d   = 1'b1;
        rd_addr_d = ptr_q + ADDR_W'(IQ_Q_OFS);
      end
      ST_FETCH_Q: begin
        pend_i_d = read_data;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pend_q_d = read_data;
        ptr_d    = ptr_q + ADDR_W'(IQ_STRIDE);
        state_d  = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (tick) begin
          out_i_d = pend_i_q;
          out_q_d = pend_q_q;
          valid_d = 1'b1;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef TX_OUTPUT_LOOP_EN
            ptr_d     = base_q;
            rem_d     = count_q;
            state_d   = ST_FETCH_I;
            rd_en_d   = 1'b1;
            rd_addr_d = base_q + ADDR_W'(IQ_I_OFS);
`else
            state_d = ST_DRAIN;
`endif
          end else begin
            state_d   = ST_FETCH_I;
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q + ADDR_W'(IQ_I_OFS);
          end
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_DRAIN: begin
        if (tick) begin
          out_i_d = '0;
          out_q_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides whatever the active state decided this cycle.
    if (stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      out_i_d   = '0;
      out_q_d   = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge dsp_clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rem_q     <= 16'd0;
      pend_i_q  <= '0;
      pend_q_q  <= '0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
`ifdef TX_OUTPUT_LOOP_EN
      base_q    <= '0;
      count_q   <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      pend_i_q  <= pend_i_d;
      pend_q_q  <= pend_q_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
`ifdef TX_OUTPUT_LOOP_EN
      base_q    <= base_d;
      count_q   <= count_d;
`endif
    end
  end

  assign read_en        = rd_en_q;
  assign read_addr      = rd_addr_q;
  assign inphase_output = out_i_q;
  assign quad_output    = out_q_q;
  assign sample_valid   = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_transmitter_output.sv
// Self-checking bench for transmitter_output: random and directed bursts are
// compared cycle by cycle against a timeline model derived from burst arithmetic.
module tb_transmitter_output;

  localparam int DIV     = 25;
  localparam int NO_STOP = 1000000;
`ifdef TX_OUTPUT_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        dsp_clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] base_addr, num_samples;
  logic        read_en;
  logic [15:0] read_addr;
  logic [15:0] read_data;
  logic [15:0] inphase_output, quad_output;
  logic        sample_valid, busy, done;

  logic [15:0] mem [0:65535];
  int          n_checks = 0;
  int          n_bad    = 0;
  int          cur_t    = 0;

  transmitter_output #(.ADDR_W(16), .DATA_W(16), .DIV(DIV)) dut (
    .dsp_clk        (dsp_clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .base_addr      (base_addr),
    .num_samples    (num_samples),
    .read_en        (read_en),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .inphase_output (inphase_output),
    .quad_output    (quad_output),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 dsp_clk = ~dsp_clk;

  // Sample memory with one-cycle read latency.
  always @(posedge dsp_clk) begin
    if (read_en) read_data <= mem[read_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=0x%0h expected=0x%0h", tag, cur_t, got, exp);
    end
  endtask

  task automatic check_all(input logic ev, input logic ed, input logic eb, input logic er,
                           input logic [15:0] ea, input logic [15:0] ei, input logic [15:0] eq);
    check_eq("sample_valid", sample_valid, ev);
    check_eq("done", done, ed);
    check_eq("busy", busy, eb);
    check_eq("read_en", read_en, er);
    check_eq("read_addr", read_addr, ea);
    check_eq("inphase", inphase_output, ei);
    check_eq("quad", quad_output, eq);
  endtask

  // Drives one burst and checks every cycle from the accept edge onward.
  // ts is the edge index (after the accept edge) at which stop is sampled.
  task automatic run_burst(input logic [15:0] base, input int n, input int ts_in);
    int ts, len, endt, j, ph, idx, fidx;
    logic ev, ed, eb, er, act;
    logic [15:0] ea, ei, eq;
    ts = ts_in;
    if (LOOP && n > 0 && ts == NO_STOP) ts = 3 * n * DIV + 4;
    if (n == 0) len = 2;
    else if (LOOP || ts < (n + 1) * DIV) len = ts + 2;
    else len = (n + 1) * DIV + 2;
    endt = (n == 0) ? 1 : ((LOOP || ts < (n + 1) * DIV) ? ts : (n + 1) * DIV);

    base_addr   = base;
    num_samples = 16'(n);
    start       = 1'b1;
    @(posedge dsp_clk); #1;
    start       = 1'b0;
    base_addr   = 16'($urandom);
    num_samples = 16'($urandom);

    for (int t = 0; t <= len; t++) begin
      cur_t = t;
      j = t / DIV;
      ph = t % DIV;
      ev = 1'b0; ed = 1'b0; eb = 1'b0; er = 1'b0;
      ea = 16'd0; ei = 16'd0; eq = 16'd0;
      if (n == 0) begin
        ed = (t == 0);
      end else if (t < ts) begin
        act  = (j >= 1) && (LOOP || j <= n);
        idx  = (j >= 1) ? (j - 1) % n : 0;
        fidx = j % n;
        eb   = LOOP || (t < (n + 1) * DIV);
        ed   = !LOOP && (t == (n + 1) * DIV);
        er   = (ph < 2) && (LOOP || j < n);
        ev   = act && (ph == 0);
        if (act) begin
          ei = mem[base + 16'(2 * idx)];
          eq = mem[base + 16'(2 * idx + 1)];
        end
        if (er) ea = base + 16'(2 * fidx + ph);
      end
      check_all(ev, ed, eb, er, ea, ei, eq);

      if (t == ts - 1) stop = 1'b1;
      if (t == ts) stop = 1'b0;
      if (t == 5 && 7 < endt) start = 1'b1;
      if (t == 6) start = 1'b0;
      @(posedge dsp_clk); #1;
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int n, ts;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    base_addr = 16'd0; num_samples = 16'd0; read_data = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    mem[16'h0012] = 16'h3333;
    mem[16'h0013] = 16'h4444;

    repeat (3) @(posedge dsp_clk);
    #1;
    cur_t = -1;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    @(posedge dsp_clk); #1;

    run_burst(16'h0010, 2, NO_STOP);
    run_burst(16'h0000, 0, NO_STOP);
    run_burst(16'h0010, 4, 31);
    run_burst(16'hFFFE, 2, NO_STOP);
    for (int k = 0; k < 5; k++) begin
      n  = int'($urandom_range(1, 4));
      ts = ($urandom_range(0, 1) == 0) ? NO_STOP : int'($urandom_range(2, (n + 1) * DIV));
      run_burst(16'($urandom), n, ts);
    end

    // Reset during WAIT_TICK of a burst.
    base_addr = 16'h0010; num_samples = 16'd3; start = 1'b1;
    @(posedge dsp_clk); #1;
    start = 1'b0;
    repeat (30) @(posedge dsp_clk);
    #1;
    rst = 1'b0;
    @(posedge dsp_clk); #1;
    rst = 1'b1;
    cur_t = -2;
    check_all(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    @(posedge dsp_clk); #1;
    run_burst(16'h0010, 2, NO_STOP);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
